// File: rtl/vga_rx_pkg.sv
// Shared types and mode-derived constants for the VGA sync receiver.
// Holds the lock FSM encoding, 16-bit counter type and timing helper functions.
package vga_rx_pkg;

  typedef logic [15:0] cnt_t;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } rx_state_e;

  function automatic int total_of(input int disp, input int front, input int sync, input int back);
    return disp + front + sync + back;
  endfunction

  // Sync pulse starts the line/frame, so active video begins after sync plus back porch.
  function automatic int act0_of(input int sync, input int back);
    return sync + back;
  endfunction

  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/vga_sync_meter.sv
// Sync edge detector with period and width counters, advanced on ce when tick is high.
// A rise seen between ticks is held pending and taken at the next tick.
module vga_sync_meter
  import vga_rx_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        tick,
  input  logic        sync_in,
  output logic        mark,
  output logic [15:0] cnt,
  output logic [15:0] wid
);

  logic sync_q_reg;
  logic pend_reg;
  cnt_t cnt_reg;
  cnt_t wid_reg;
  logic rise;

  assign rise = sync_in & ~sync_q_reg;
  assign mark = ce & tick & (rise | pend_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q_reg <= 1'b0;
      pend_reg   <= 1'b0;
      cnt_reg    <= '0;
      wid_reg    <= '0;
    end else if (ce) begin
      sync_q_reg <= sync_in;
      if (mark)
        pend_reg <= 1'b0;
      else if (rise)
        pend_reg <= 1'b1;
      if (tick) begin
        cnt_reg <= mark ? '0 : sat_inc(cnt_reg);
        // Width uses the previous sample so it covers the period that just ended.
        wid_reg <= mark ? '0 : (sync_q_reg ? sat_inc(wid_reg) : wid_reg);
      end
    end
  end

  assign cnt = cnt_reg;
  assign wid = wid_reg;

endmodule

// File: rtl/vga_sync_receiver.sv
// VGA sink: recovers x/y/de from Hsync/Vsync, checks timing, tracks lock and errors.
// Define VGA_RX_BLANK_CHECK_EN to flag non-black samples in blanking (sticky blank_err).
module vga_sync_receiver
  import vga_rx_pkg::*;
#(
  parameter int H_DISPLAY   = 640,
  parameter int H_BACK      = 48,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int V_DISPLAY   = 480,
  parameter int V_BACK      = 33,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_ce,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [3:0]  red_in,
  input  logic [3:0]  green_in,
  input  logic [3:0]  blue_in,
  output logic [15:0] x_out,
  output logic [15:0] y_out,
  output logic        de_out,
  output logic [3:0]  red_out,
  output logic [3:0]  green_out,
  output logic [3:0]  blue_out,
  output logic        locked,
  output logic        err_pulse,
  output logic [7:0]  err_count,
  output logic        blank_err
);

  localparam cnt_t H_TOTAL  = cnt_t'(total_of(H_DISPLAY, H_FRONT, H_SYNC, H_BACK));
  localparam cnt_t V_TOTAL  = cnt_t'(total_of(V_DISPLAY, V_FRONT, V_SYNC, V_BACK));
  localparam cnt_t H_ACT0   = cnt_t'(act0_of(H_SYNC, H_BACK));
  localparam cnt_t V_ACT0   = cnt_t'(act0_of(V_SYNC, V_BACK));
  localparam cnt_t H_ACT1   = H_ACT0 + cnt_t'(H_DISPLAY);
  localparam cnt_t V_ACT1   = V_ACT0 + cnt_t'(V_DISPLAY);
  localparam cnt_t H_LAST   = H_TOTAL - 16'd1;
  localparam cnt_t V_LAST   = V_TOTAL - 16'd1;
  localparam cnt_t H_LIMIT  = cnt_t'(2 * total_of(H_DISPLAY, H_FRONT, H_SYNC, H_BACK) - 1);
  localparam cnt_t H_SYNC_W = cnt_t'(H_SYNC);
  localparam cnt_t V_SYNC_W = cnt_t'(V_SYNC);
  localparam logic [7:0] LOCK_GOOD = 8'(LOCK_FRAMES);

  localparam logic [1:0] ST_SEARCH = SEARCH;
  localparam logic [1:0] ST_VERIFY = VERIFY;
  localparam logic [1:0] ST_LOCKED = LOCKED;

  logic        h_mark;
  logic        v_mark;
  logic [15:0] hcnt;
  logic [15:0] hwid;
  logic [15:0] vcnt;
  logic [15:0] vwid;

  vga_sync_meter u_hmeter (
    .clk     (clk),
    .rst     (rst),
    .ce      (pix_ce),
    .tick    (1'b1),
    .sync_in (hsync_in),
    .mark    (h_mark),
    .cnt     (hcnt),
    .wid     (hwid)
  );

  vga_sync_meter u_vmeter (
    .clk     (clk),
    .rst     (rst),
    .ce      (pix_ce),
    .tick    (h_mark),
    .sync_in (vsync_in),
    .mark    (v_mark),
    .cnt     (vcnt),
    .wid     (vwid)
  );

  logic [1:0] state_reg, state_next;
  logic [7:0] good_reg, good_next;
  logic       h_armed_reg, h_armed_next;
  logic       locked_reg;
  logic       err_pulse_reg;
  logic [7:0] err_count_reg;
  logic [3:0] red_reg, green_reg, blue_reg;
  logic       line_err, frame_err, timeout_err, err_now;

  // Frame checks are skipped in SEARCH, which covers the first boundary after any error.
  assign line_err    = h_mark & h_armed_reg & ((hcnt != H_LAST) | (hwid != H_SYNC_W));
  assign frame_err   = v_mark & (state_reg != ST_SEARCH) & ((vcnt != V_LAST) | (vwid != V_SYNC_W));
  assign timeout_err = pix_ce & ~h_mark & (hcnt == H_LIMIT);
  assign err_now     = line_err | frame_err | timeout_err;

  always_comb begin
    state_next   = state_reg;
    good_next    = good_reg;
    h_armed_next = h_armed_reg;
    if (h_mark)
      h_armed_next = 1'b1;
    if (err_now) begin
      state_next   = ST_SEARCH;
      good_next    = '0;
      h_armed_next = 1'b0;
    end else if (v_mark) begin
      case (state_reg)
        ST_SEARCH: begin
          state_next = ST_VERIFY;
          good_next  = '0;
        end
        ST_VERIFY: begin
          good_next = good_reg + 8'd1;
          if (good_reg + 8'd1 == LOCK_GOOD)
            state_next = ST_LOCKED;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_SEARCH;
      good_reg      <= '0;
      h_armed_reg   <= 1'b0;
      locked_reg    <= 1'b0;
      err_pulse_reg <= 1'b0;
      err_count_reg <= '0;
      red_reg       <= '0;
      green_reg     <= '0;
      blue_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      good_reg      <= good_next;
      h_armed_reg   <= h_armed_next;
      locked_reg    <= (state_reg == ST_LOCKED);
      err_pulse_reg <= err_now;
      if (err_now && err_count_reg != 8'hFF)
        err_count_reg <= err_count_reg + 8'd1;
      if (pix_ce) begin
        red_reg   <= red_in;
        green_reg <= green_in;
        blue_reg  <= blue_in;
      end
    end
  end

  logic in_h, in_v;
  assign in_h      = (hcnt >= H_ACT0) && (hcnt < H_ACT1);
  assign in_v      = (vcnt >= V_ACT0) && (vcnt < V_ACT1);
  assign de_out    = locked_reg & in_h & in_v;
  assign x_out     = de_out ? hcnt - H_ACT0 : 16'd0;
  assign y_out     = de_out ? vcnt - V_ACT0 : 16'd0;
  assign red_out   = red_reg;
  assign green_out = green_reg;
  assign blue_out  = blue_reg;
  assign locked    = locked_reg;
  assign err_pulse = err_pulse_reg;
  assign err_count = err_count_reg;

`ifdef VGA_RX_BLANK_CHECK_EN
  logic blank_err_reg;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      blank_err_reg <= 1'b0;
    else if (pix_ce && locked_reg && !de_out && (|{red_reg, green_reg, blue_reg}))
      blank_err_reg <= 1'b1;
  end
  assign blank_err = blank_err_reg;
`else
  assign blank_err = 1'b0;
`endif

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench for vga_sync_receiver using a reduced video mode (26x11 total)
// so lock, error and relock sequences fit in a short run; pix_ce every 4th clk.
module tb_vga_sync_receiver;

  localparam int HD = 16, HB = 4, HF = 2, HS = 4;
  localparam int VD = 6,  VB = 2, VF = 1, VS = 2;
  localparam int HT = HD + HB + HF + HS;   // 26
  localparam int VT = VD + VB + VF + VS;   // 11
  localparam int HA0 = HS + HB;            // 8
  localparam int VA0 = VS + VB;            // 4

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pix_ce = 1'b0;
  logic        hsync_in = 1'b0;
  logic        vsync_in = 1'b0;
  logic [3:0]  red_in = '0, green_in = '0, blue_in = '0;
  logic [15:0] x_out, y_out;
  logic        de_out;
  logic [3:0]  red_out, green_out, blue_out;
  logic        locked, err_pulse, blank_err;
  logic [7:0]  err_count;

  int n_vec = 0;
  int n_err = 0;
  int pulse_cnt = 0;
  int frame_no = 0;

`ifdef VGA_RX_BLANK_CHECK_EN
  localparam logic BLANK_EXP = 1'b1;
`else
  localparam logic BLANK_EXP = 1'b0;
`endif

  vga_sync_receiver #(
    .H_DISPLAY(HD), .H_BACK(HB), .H_FRONT(HF), .H_SYNC(HS),
    .V_DISPLAY(VD), .V_BACK(VB), .V_FRONT(VF), .V_SYNC(VS),
    .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .rst(rst), .pix_ce(pix_ce),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .x_out(x_out), .y_out(y_out), .de_out(de_out),
    .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count),
    .blank_err(blank_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (err_pulse === 1'b1) pulse_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic strobe(input logic hs, input logic vs, input logic [3:0] r,
                        input logic [3:0] g, input logic [3:0] b);
    @(negedge clk);
    hsync_in = hs; vsync_in = vs; red_in = r; green_in = g; blue_in = b; pix_ce = 1'b1;
    @(negedge clk);
    pix_ce = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  // Checks after the strobe at (v,h), i.e. with hcnt=h and vcnt=v.
  task automatic probe_px(input int v, input int h);
    if (v == VA0 && h == HA0 - 1) chk("de_left_edge", 32'(de_out), 32'd0);
    if (v == VA0 && h == HA0) begin
      chk("de_first", 32'(de_out), 32'd1);
      chk("x_first", 32'(x_out), 32'd0);
      chk("y_first", 32'(y_out), 32'd0);
      chk("blue_first", 32'(blue_out), 32'hA);
    end
    if (v == VA0 && h == HA0 + HD - 1) begin
      chk("de_last_col", 32'(de_out), 32'd1);
      chk("x_last_col", 32'(x_out), 32'(HD - 1));
      chk("red_last_col", 32'(red_out), 32'hF);
    end
    if (v == VA0 && h == HA0 + HD) begin
      chk("de_right_edge", 32'(de_out), 32'd0);
      chk("x_right_edge", 32'(x_out), 32'd0);
    end
    if (v == VA0 + VD - 1 && h == HA0 + 1) begin
      chk("y_last_row", 32'(y_out), 32'(VD - 1));
      chk("x_last_row", 32'(x_out), 32'd1);
      chk("green_last_row", 32'(green_out), 32'd5);
    end
    if (v == VA0 + VD && h == HA0) begin
      chk("de_below", 32'(de_out), 32'd0);
      chk("y_below", 32'(y_out), 32'd0);
    end
  endtask

  task automatic mid_reset();
    chk("pre_rst_de", 32'(de_out), 32'd1);
    chk("pre_rst_x", 32'(x_out), 32'd3);
    chk("pre_rst_errcnt", 32'(err_count), 32'd4);
    #2 rst = 1'b1;
    #1;
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_de", 32'(de_out), 32'd0);
    chk("rst_x", 32'(x_out), 32'd0);
    chk("rst_y", 32'(y_out), 32'd0);
    chk("rst_errcnt", 32'(err_count), 32'd0);
    chk("rst_blue", 32'(blue_out), 32'd0);
    chk("rst_blank", 32'(blank_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // probe: 1 = active-area checks plus one non-black blanking sample, 2 = reset mid-frame
  task automatic send_frame(input int long_line, input int short_hs_line, input int vs_w, input int probe);
    for (int v = 0; v < VT; v++) begin
      int len;
      int hw;
      len = (v == long_line) ? HT + 1 : HT;
      hw  = (v == short_hs_line) ? HS - 1 : HS;
      for (int h = 0; h < len; h++) begin
        logic act;
        logic [3:0] r, g, b;
        act = (h >= HA0) && (h < HA0 + HD) && (v >= VA0) && (v < VA0 + VD);
        r = act ? 4'(h - HA0) : 4'd0;
        g = act ? 4'(v - VA0) : 4'd0;
        b = act ? 4'hA : 4'd0;
        if (probe == 1 && v == 1 && h == 10) r = 4'hF;
        strobe(h < hw, v < vs_w, r, g, b);
        if (probe == 1) probe_px(v, h);
        if (probe == 2 && v == VA0 + 1 && h == HA0 + 3) mid_reset();
      end
    end
    frame_no++;
    $display("frame %0d: locked=%0d err_count=%0d err_pulses=%0d blank_err=%0d",
             frame_no, locked, err_count, pulse_cnt, blank_err);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_locked", 32'(locked), 32'd0);
    chk("reset_de", 32'(de_out), 32'd0);
    chk("reset_x", 32'(x_out), 32'd0);
    chk("reset_y", 32'(y_out), 32'd0);
    chk("reset_err_pulse", 32'(err_pulse), 32'd0);
    chk("reset_err_count", 32'(err_count), 32'd0);
    chk("reset_red", 32'(red_out), 32'd0);
    chk("reset_blank", 32'(blank_err), 32'd0);
    rst = 1'b0;

    // Ideal stream: lock on the 3rd boundary (start of frame 3)
    send_frame(-1, -1, VS, 0);
    send_frame(-1, -1, VS, 0);
    chk("prelock_locked", 32'(locked), 32'd0);
    send_frame(-1, -1, VS, 1);
    chk("lock_locked", 32'(locked), 32'd1);
    chk("lock_errcnt", 32'(err_count), 32'd0);
    chk("lock_pulses", 32'(pulse_cnt), 32'd0);
    chk("blank_flag", 32'(blank_err), 32'(BLANK_EXP));

    // One 27-pixel line while locked
    send_frame(3, -1, VS, 0);
    chk("longline_errcnt", 32'(err_count), 32'd1);
    chk("longline_pulses", 32'(pulse_cnt), 32'd1);
    chk("longline_locked", 32'(locked), 32'd0);
    send_frame(-1, -1, VS, 0);
    send_frame(-1, -1, VS, 0);
    chk("relock_early", 32'(locked), 32'd0);
    send_frame(-1, -1, VS, 0);
    chk("relock_locked", 32'(locked), 32'd1);
    chk("blank_sticky", 32'(blank_err), 32'(BLANK_EXP));

    // Short hsync, then a 3-line vsync frame checked at the following boundary
    send_frame(-1, 3, VS, 0);
    chk("hwid_errcnt", 32'(err_count), 32'd2);
    chk("hwid_locked", 32'(locked), 32'd0);
    send_frame(-1, -1, VS + 1, 0);
    chk("vwid_pending", 32'(err_count), 32'd2);
    send_frame(-1, -1, VS, 0);
    chk("vwid_errcnt", 32'(err_count), 32'd3);
    chk("vwid_pulses", 32'(pulse_cnt), 32'd3);

    // Hsync held low: hcnt ends last line at HT-1, crosses 2*HT-1 -> 2*HT after HT+1 strobes
    for (int i = 0; i < HT; i++) strobe(1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
    chk("timeout_before", 32'(err_count), 32'd3);
    strobe(1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
    chk("timeout_errcnt", 32'(err_count), 32'd4);
    chk("timeout_pulses", 32'(pulse_cnt), 32'd4);

    // Relock, then reset in the middle of a locked frame
    send_frame(-1, -1, VS, 0);
    send_frame(-1, -1, VS, 0);
    send_frame(-1, -1, VS, 2);
    chk("postrst_errcnt", 32'(err_count), 32'd0);
    chk("postrst_locked", 32'(locked), 32'd0);
    send_frame(-1, -1, VS, 0);
    send_frame(-1, -1, VS, 0);
    chk("postrst_early", 32'(locked), 32'd0);
    send_frame(-1, -1, VS, 0);
    chk("postrst_relock", 32'(locked), 32'd1);
    chk("final_errcnt", 32'(err_count), 32'd0);
    chk("final_pulses", 32'(pulse_cnt), 32'd4);
    chk("final_blank", 32'(blank_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
